kb_search_ctrl: RTL and testbench
=================================

// Module: kb_search_ctrl
// PURPOSE
// Scheduler for the key-block search engine. On start it walks a range of candidate
// key blocks (base_kb with an incrementing low counter) and dispatches each candidate
// to one of NUM_UNITS aes_kb workers, round-robin among idle workers. It collects
// done/valid, captures the first valid key, drains outstanding work, then reports.
// PARAMETERS
// NUM_UNITS  2   number of aes_kb workers driven (1..8)
// CTR_W      32  width of candidate counter, replaces kb[CTR_W-1:0]
// PORTS
// clk          in   1               clock, rising edge
// rst          in   1               asynchronous, active-low reset
// start        in   1               1-cycle pulse; accepted only in IDLE
// abort        in   1               stop dispatch, drain, report (found unchanged)
// stall        in   1               when 1, no new dispatch this cycle
// base_kb      in   448             candidate template, latched on start
// count_limit  in   CTR_W           number of candidates, latched on start
// in_buf       in   384             ciphertext, latched on start
// buf_q        out  384             latched in_buf, shared by all workers
// unit_start   out  NUM_UNITS       per-worker 1-cycle start pulse
// unit_kb      out  NUM_UNITS*448   per-worker candidate, slice i = [i*448 +: 448]
// unit_done    in   NUM_UNITS       per-worker 1-cycle completion pulse
// unit_valid   in   NUM_UNITS       qualifies unit_done: key verified
// unit_key     in   NUM_UNITS*128   per-worker key, sampled when unit_done
// busy         out  1               1 in DISPATCH/DRAIN/REPORT
// done         out  1               1-cycle pulse at end of search
// found        out  1               valid key captured this search
// found_key    out  128             captured key
// found_idx    out  CTR_W           candidate counter of captured key
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, rr pointer 0, all workers marked idle.
// - Candidate n: kb = {base_kb[447:CTR_W], base_kb[CTR_W-1:0] + n} mod 2^CTR_W;
//   n counts 0..count_limit-1; unit_kb slice held stable from dispatch until done.
// - States: IDLE -> DISPATCH (start); DISPATCH -> DRAIN (all issued, valid seen, or
//   abort); DRAIN -> REPORT (no worker busy); REPORT -> IDLE (done=1 one cycle).
// - start with count_limit==0: IDLE -> REPORT directly; done next cycle, found=0.
// - start clears found/found_key/found_idx; results otherwise hold until next start.
// - DISPATCH: at most one dispatch per cycle; if !stall and any worker idle, grant
//   lowest-index idle worker at or after rr pointer (wrapping); pulse its unit_start,
//   mark busy, store its n; rr pointer <- granted+1 mod NUM_UNITS; n <- n+1.
// - unit_done[i] in any non-IDLE state frees worker i that cycle (dispatch to it
//   possible next cycle, not same cycle). unit_done for an idle worker is ignored.
// - First valid wins: if found==0 and unit_done&unit_valid, capture key and its n;
//   simultaneous valids -> lowest worker index. Later valids ignored.
// - Valid seen or abort: no further dispatch, even if stall low and workers idle.
// - start while busy is ignored. abort in IDLE/REPORT ignored.
// - rst low mid-search: immediate return to reset values; workers see no start.
// TESTING
// - NUM_UNITS=2, count_limit=4, workers done 3 cycles after start, never valid ->
//   unit_start order u0,u1,u0,u1 with low kb +0..+3; done once; found=0.
// - count_limit=6, worker returns valid on n=2, key=128'hA5..A5 -> found=1,
//   found_idx=2, found_key=A5..A5; no dispatch of n>=4 after valid; done after drain.
// - Both workers done+valid same cycle (n=0,n=1) -> found_idx=0 (worker 0 wins).
// - stall held 5 cycles mid-search -> no unit_start during stall; n resumes unchanged.
// - base_kb low 32 bits = 32'hFFFF_FFFE, count_limit=3 -> low kb FFFFFFFE,
//   FFFFFFFF, 00000000; upper bits unchanged.
// - count_limit=0 -> done 1 cycle later, no unit_start; rst low mid-DISPATCH ->
//   busy=0, unit_start=0 asynchronously; next start runs clean.

Source files
------------

// File: rtl/kb_search_ctrl.sv
// Key-block search scheduler: walks a candidate range, dispatches round-robin to idle
// aes_kb workers, captures the first verified key, drains outstanding work, reports.
module kb_search_ctrl #(
  parameter int NUM_UNITS = 2,
  parameter int CTR_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     stall,
  input  logic [447:0]             base_kb,
  input  logic [CTR_W-1:0]         count_limit,
  input  logic [383:0]             in_buf,
  output logic [383:0]             buf_q,
  output logic [NUM_UNITS-1:0]     unit_start,
  output logic [NUM_UNITS*448-1:0] unit_kb,
  input  logic [NUM_UNITS-1:0]     unit_done,
  input  logic [NUM_UNITS-1:0]     unit_valid,
  input  logic [NUM_UNITS*128-1:0] unit_key,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic [127:0]             found_key,
  output logic [CTR_W-1:0]         found_idx
);
  localparam int KBW = 448;
  localparam int RRW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_REPORT} state_e;

  state_e                          state_q, state_d;
  logic [RRW-1:0]                  rr_q, rr_d;
  logic [NUM_UNITS-1:0]            act_q, act_d;
  logic [NUM_UNITS-1:0][CTR_W-1:0] un_q, un_d;
  logic [NUM_UNITS-1:0][KBW-1:0]   kb_q, kb_d;
  logic [NUM_UNITS-1:0]            start_q, start_d;
  logic [CTR_W-1:0]                n_q, n_d, limit_q, limit_d;
  logic [KBW-1:0]                  base_q, base_d;
  logic [383:0]                    in_buf_q, in_buf_d;
  logic                            found_q, found_d, done_q, done_d, busy_q, busy_d;
  logic [127:0]                    found_key_q, found_key_d;
  logic [CTR_W-1:0]                found_idx_q, found_idx_d;

  logic [NUM_UNITS-1:0] fin, hit, gnt;
  logic                 gnt_any, cap, stop;
  logic [127:0]         cap_key;
  logic [CTR_W-1:0]     cap_idx;

  always_comb begin
    fin     = unit_done & act_q;
    hit     = fin & unit_valid;
    cap     = 1'b0;
    cap_key = '0;
    cap_idx = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (hit[i] && !cap) begin
        cap     = 1'b1;
        cap_key = unit_key[i*128 +: 128];
        cap_idx = un_q[i];
      end
    end
    // Search idle workers starting at the rr pointer; a worker freed this cycle
    // is still marked active, so it can only be granted next cycle.
    gnt     = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (!gnt_any && !act_q[i] && i == (int'(rr_q) + k) % NUM_UNITS) begin
          gnt[i]  = 1'b1;
          gnt_any = 1'b1;
        end
      end
    end
    stop = abort | cap | found_q;

    state_d     = state_q;
    rr_d        = rr_q;
    act_d       = (state_q == S_IDLE) ? act_q : (act_q & ~fin);
    un_d        = un_q;
    kb_d        = kb_q;
    start_d     = '0;
    n_d         = n_q;
    limit_d     = limit_q;
    base_d      = base_q;
    in_buf_d    = in_buf_q;
    found_d     = found_q;
    found_key_d = found_key_q;
    found_idx_d = found_idx_q;

    if (state_q != S_IDLE && !found_q && cap) begin
      found_d     = 1'b1;
      found_key_d = cap_key;
      found_idx_d = cap_idx;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d      = base_kb;
          limit_d     = count_limit;
          in_buf_d    = in_buf;
          n_d         = '0;
          found_d     = 1'b0;
          found_key_d = '0;
          found_idx_d = '0;
          state_d     = (count_limit == '0) ? S_REPORT : S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (!stall && !stop && gnt_any) begin
          start_d = gnt;
          act_d   = act_d | gnt;
          for (int i = 0; i < NUM_UNITS; i++) begin
            if (gnt[i]) begin
              un_d[i] = n_q;
              kb_d[i] = {base_q[KBW-1:CTR_W], base_q[CTR_W-1:0] + n_q};
              rr_d    = RRW'((i + 1) % NUM_UNITS);
            end
          end
          n_d = n_q + CTR_W'(1);
        end
        if (stop || n_d == limit_q) state_d = S_DRAIN;
      end
      S_DRAIN:  if (act_d == '0) state_d = S_REPORT;
      default:  state_d = S_IDLE;
    endcase

    done_d = (state_d == S_REPORT);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      act_q       <= '0;
      un_q        <= '0;
      kb_q        <= '0;
      start_q     <= '0;
      n_q         <= '0;
      limit_q     <= '0;
      base_q      <= '0;
      in_buf_q    <= '0;
      found_q     <= 1'b0;
      found_key_q <= '0;
      found_idx_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      act_q       <= act_d;
      un_q        <= un_d;
      kb_q        <= kb_d;
      start_q     <= start_d;
      n_q         <= n_d;
      limit_q     <= limit_d;
      base_q      <= base_d;
      in_buf_q    <= in_buf_d;
      found_q     <= found_d;
      found_key_q <= found_key_d;
      found_idx_q <= found_idx_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign buf_q      = in_buf_q;
  assign unit_start = start_q;
  assign unit_kb    = kb_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign found_key  = found_key_q;
  assign found_idx  = found_idx_q;
endmodule

// File: tb/tb_kb_search_ctrl.sv
// Bench for kb_search_ctrl: behavioural scheduler model compared every cycle, plus
// directed searches with hand-computed dispatch orders, counters and captured keys.
module tb_kb_search_ctrl;
  logic         clk, rst, start, abort, stall;
  logic [447:0] base_kb;
  logic [31:0]  count_limit;
  logic [383:0] in_buf, buf_q;
  logic [1:0]   unit_start, unit_done, unit_valid;
  logic [895:0] unit_kb;
  logic [255:0] unit_key;
  logic         busy, done, found;
  logic [127:0] found_key;
  logic [31:0]  found_idx;

  kb_search_ctrl #(.NUM_UNITS(2), .CTR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
    .base_kb(base_kb), .count_limit(count_limit), .in_buf(in_buf), .buf_q(buf_q),
    .unit_start(unit_start), .unit_kb(unit_kb), .unit_done(unit_done),
    .unit_valid(unit_valid), .unit_key(unit_key), .busy(busy), .done(done),
    .found(found), .found_key(found_key), .found_idx(found_idx));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, last_done_cyc = 0, last_start_cyc = 0;
  int lw[$];
  logic [31:0]  llow[$];
  logic [415:0] lup[$];

  task automatic chk(input string nm, input logic [447:0] act, input logic [447:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [447:0] kb_of(input logic [447:0] b, input logic [31:0] n);
    return {b[447:32], b[31:0] + n};
  endfunction

  function automatic logic [127:0] key_of(input logic [31:0] n);
    return {16{8'hA5}} ^ {96'd0, n ^ 32'd2};
  endfunction

  // Worker responders: done/valid/key a fixed latency after each unit_start.
  int lat[2];
  int wcnt[2];
  logic [31:0] wn[2];
  logic [31:0] vlo, vhi;
  always @(posedge clk) begin
    #1;
    unit_done  = '0;
    unit_valid = '0;
    if (!rst) begin
      for (int i = 0; i < 2; i++) wcnt[i] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wcnt[i] > 0) begin
          wcnt[i]--;
          if (wcnt[i] == 0) begin
            unit_done[i]  = 1'b1;
            unit_valid[i] = (wn[i] >= vlo && wn[i] <= vhi);
            unit_key[i*128 +: 128] = key_of(wn[i]);
          end
        end
        if (unit_start[i]) begin
          wcnt[i] = lat[i];
          wn[i]   = unit_kb[i*448 +: 32] - base_kb[31:0];
        end
      end
    end
  end

  // Scheduler model: phase 0 idle, 1 dispatching, 2 draining, 3 reporting.
  int           ph;
  logic [1:0]   mbusy, exp_start;
  logic         mrr;
  logic [31:0]  missued, mlimit, midx;
  logic [31:0]  mn[2];
  logic [447:0] mbase;
  logic [383:0] mbuf;
  logic         mfound;
  logic [127:0] mkey;

  always @(negedge clk) begin
    logic [1:0] fin, hit;
    logic       gv, gi, cap, idx;
    cyc++;
    if (!rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_ustart", unit_start, 0);
      chk("rst_done", done, 0);
      chk("rst_found", found, 0);
      ph = 0; mbusy = 0; exp_start = 0; mrr = 0; missued = 0; mlimit = 0;
      midx = 0; mbase = 0; mbuf = 0; mfound = 0; mkey = 0;
    end else begin
      chk("busy", busy, ph != 0);
      chk("done", done, ph == 3);
      chk("unit_start", unit_start, exp_start);
      chk("found", found, mfound);
      chk("found_key", found_key, mkey);
      chk("found_idx", found_idx, midx);
      chk("buf_q", buf_q, mbuf);
      for (int i = 0; i < 2; i++)
        if (mbusy[i]) chk("unit_kb", unit_kb[i*448 +: 448], kb_of(mbase, mn[i]));
      for (int i = 0; i < 2; i++)
        if (unit_start[i]) begin
          lw.push_back(i);
          llow.push_back(unit_kb[i*448 +: 32]);
          lup.push_back(unit_kb[i*448+32 +: 416]);
        end
      if (done) begin done_cnt++; last_done_cyc = cyc; end

      fin = unit_done & mbusy;
      hit = fin & unit_valid;
      cap = 1'b0;
      if (ph != 0 && !mfound)
        for (int i = 0; i < 2; i++)
          if (hit[i] && !cap) begin
            cap = 1'b1; mfound = 1'b1; mkey = unit_key[i*128 +: 128]; midx = mn[i];
          end
      gv = 1'b0; gi = 1'b0;
      if (ph == 1 && !stall && !abort && hit == 0 && missued < mlimit)
        for (int k = 0; k < 2; k++) begin
          idx = mrr ^ k[0];
          if (!gv && !mbusy[idx]) begin gv = 1'b1; gi = idx; end
        end
      exp_start = gv ? (2'b01 << gi) : 2'b00;
      if (ph != 0) mbusy = mbusy & ~fin;
      if (gv) begin
        mbusy[gi] = 1'b1; mn[gi] = missued; missued++; mrr = ~gi;
      end
      case (ph)
        0: if (start) begin
             mbase = base_kb; mlimit = count_limit; mbuf = in_buf; missued = 0;
             mfound = 0; mkey = 0; midx = 0; last_start_cyc = cyc;
             ph = (count_limit == 0) ? 3 : 1;
           end
        1: if (abort || hit != 0 || missued == mlimit) ph = 2;
        2: if (mbusy == 0) ph = 3;
        default: ph = 0;
      endcase
    end
  end

  function automatic logic [447:0] mk_base(input logic [31:0] low);
    logic [447:0] b;
    b = {14{$urandom}};
    b[31:0] = low;
    return b;
  endfunction

  task automatic run_search(input logic [447:0] b, input logic [31:0] lim, input int l0, l1,
                            input logic [31:0] lo, hi, input int st_at, st_len, ab_at);
    int d0, k;
    base_kb = b; count_limit = lim; in_buf = {12{$urandom}};
    lat[0] = l0; lat[1] = l1; vlo = lo; vhi = hi;
    lw.delete(); llow.delete(); lup.delete();
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 400) begin
      stall = (k >= st_at && k < st_at + st_len);
      abort = (k == ab_at);
      @(posedge clk); #1;
      k++;
    end
    stall = 1'b0; abort = 1'b0;
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL search_timeout: no done after %0d cycles, required done", k);
    end
    @(posedge clk); #1;
    chk("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    logic [447:0] b;
    rst = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
    base_kb = '0; count_limit = '0; in_buf = '0; unit_key = '0;
    lat[0] = 3; lat[1] = 3; vlo = 32'hFFFF_FFFF; vhi = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_found_key", found_key, 0);
    #2 rst = 1'b1;

    // Four candidates, never valid: u0,u1,u0,u1 with low kb +0..+3.
    b = mk_base(32'h0000_1000);
    run_search(b, 4, 3, 3, 32'hFFFF_FFFF, 0, 0, 0, -1);
    chk("t1_count", lw.size(), 4);
    for (int i = 0; i < lw.size() && i < 4; i++) begin
      chk("t1_worker", lw[i], i % 2);
      chk("t1_low", llow[i], 32'h0000_1000 + i);
    end
    chk("t1_found", found, 0);

    // Valid on n=2: capture A5 key, nothing at or beyond n=4 dispatched.
    b = mk_base(32'h0000_2000);
    run_search(b, 6, 3, 3, 2, 2, 0, 0, -1);
    chk("t2_found", found, 1);
    chk("t2_idx", found_idx, 2);
    chk("t2_key", found_key, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5);
    chk("t2_count", lw.size(), 4);
    for (int i = 0; i < lw.size(); i++) chk("t2_low", llow[i], 32'h0000_2000 + i);

    // Both workers valid in the same cycle (n=0 on u0, n=1 on u1): u0 wins.
    b = mk_base(32'h0000_3000);
    run_search(b, 4, 4, 3, 0, 1, 0, 0, -1);
    chk("t3_found", found, 1);
    chk("t3_idx", found_idx, 0);
    chk("t3_key", found_key, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A7);

    // Stall for 5 cycles mid-search; counter resumes without gaps.
    b = mk_base(32'h0000_4000);
    run_search(b, 6, 3, 3, 32'hFFFF_FFFF, 0, 4, 5, -1);
    chk("t4_count", lw.size(), 6);
    for (int i = 0; i < lw.size() && i < 6; i++) chk("t4_low", llow[i], 32'h0000_4000 + i);
    chk("t4_found", found, 0);

    // Low counter wrap; upper template bits untouched.
    b = mk_base(32'hFFFF_FFFE);
    run_search(b, 3, 3, 3, 32'hFFFF_FFFF, 0, 0, 0, -1);
    chk("t5_count", lw.size(), 3);
    if (lw.size() == 3) begin
      chk("t5_low0", llow[0], 32'hFFFF_FFFE);
      chk("t5_low1", llow[1], 32'hFFFF_FFFF);
      chk("t5_low2", llow[2], 32'h0000_0000);
      chk("t5_upper", lup[2], b[447:32]);
    end

    // Abort mid-dispatch: dispatch stops early, found stays clear.
    b = mk_base(32'h0000_6000);
    run_search(b, 20, 3, 3, 32'hFFFF_FFFF, 0, 0, 0, 6);
    checks++;
    if (lw.size() >= 20) begin
      errors++;
      $display("FAIL t6_abort_count: got %0d dispatches, required fewer than 20", lw.size());
    end
    chk("t6_found", found, 0);

    // count_limit == 0: done the cycle after start, no dispatch.
    b = mk_base(32'h0000_7000);
    run_search(b, 0, 3, 3, 32'hFFFF_FFFF, 0, 0, 0, -1);
    chk("t7_latency", last_done_cyc - last_start_cyc, 1);
    chk("t7_count", lw.size(), 0);
    chk("t7_found", found, 0);

    // Asynchronous reset mid-dispatch, then a clean search.
    base_kb = mk_base(32'h0000_8000); count_limit = 10; lat[0] = 3; lat[1] = 3;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ustart", unit_start, 0);
    chk("arst_done", done, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    b = mk_base(32'h0000_9000);
    run_search(b, 2, 3, 3, 32'hFFFF_FFFF, 0, 0, 0, -1);
    chk("t8_count", lw.size(), 2);
    if (lw.size() == 2) begin
      chk("t8_w0", lw[0], 0);
      chk("t8_w1", lw[1], 1);
      chk("t8_low1", llow[1], 32'h0000_9001);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required $finish");
    $fatal(1);
  end
endmodule
